// File: rtl/sumador_secuencial_n_bits.sv
// Multi-cycle N-bit adder/subtractor: one K-bit ripple slice per clock, carry held in a register.
// done, Cout and the status flags are registered on the cycle after the last slice.
module sumador_secuencial_n_bits #(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         resta,
  output logic [N-1:0] R,
  output logic         Cout,
  output logic         overflow,
  output logic         zero,
  output logic         negative,
  output logic         busy,
  output logic         done
);

  localparam int S  = N / K;
  localparam int CW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {IDLE, SUMA, FIN} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   opa_q, opa_d, opb_q, opb_d, r_q, r_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           carry_q, carry_d, cmsb_q, cmsb_d;
  logic           cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;
  logic           busy_q, busy_d, done_q, done_d;

  logic [K-1:0]   a_sl, b_sl;
  logic [K:0]     sum_sl;
  logic           cin_msb;
  logic           accept;

  // Slice datapath: K full-adder stages; carry into the slice MSB recovered from its sum bit.
  always_comb begin
    a_sl    = opa_q[cnt_q*K +: K];
    b_sl    = opb_q[cnt_q*K +: K];
    sum_sl  = {1'b0, a_sl} + {1'b0, b_sl} + {{K{1'b0}}, carry_q};
    cin_msb = sum_sl[K-1] ^ a_sl[K-1] ^ b_sl[K-1];
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    accept  = start && (state_q == IDLE || state_q == FIN);

    case (state_q)
      IDLE: ;
      SUMA: begin
        r_d[cnt_q*K +: K] = sum_sl[K-1:0];
        carry_d           = sum_sl[K];
        cmsb_d            = cin_msb;
        if (cnt_q == CW'(S - 1)) state_d = FIN;
        else                     cnt_d   = cnt_q + CW'(1);
      end
      FIN: begin
        done_d  = 1'b1;
        cout_d  = carry_q;
        ovf_d   = cmsb_q ^ carry_q;
        zero_d  = (r_q == '0);
        neg_d   = r_q[N-1];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Subtraction is A + ~B + 1; Cin only matters for addition.
    if (accept) begin
      opa_d   = A;
      opb_d   = resta ? ~B : B;
      carry_d = resta ? 1'b1 : Cin;
      cnt_d   = '0;
      state_d = SUMA;
    end

    busy_d = (state_d != IDLE) || (state_q == FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign R        = r_q;
  assign Cout     = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign negative = neg_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sumador_secuencial_n_bits.sv
// Scoreboard bench: directed N=8/K=4 vectors plus a random sweep of N=16 with K=1, 4, 16.
module tb_sumador_secuencial_n_bits;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic       rst, start, cin, resta;
  logic [7:0] a, b, r;
  logic       cout, ovf, zero, neg, busy, done;

  sumador_secuencial_n_bits #(.N(8), .K(4)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .Cin(cin), .resta(resta),
    .R(r), .Cout(cout), .overflow(ovf), .zero(zero), .negative(neg),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [7:0]  r;
    logic        c, v, z, n;
    int unsigned due;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  always @(negedge clk) begin
    if (done) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL spurious_done got r=%h at cyc=%0d, no result expected", r, cyc);
      end else begin
        e = exp_q.pop_front();
        if ({r, cout, ovf, zero, neg} !== {e.r, e.c, e.v, e.z, e.n} || cyc != e.due || busy !== 1'b1) begin
          bad++;
          $display("FAIL result got r=%h c=%b v=%b z=%b n=%b cyc=%0d busy=%b exp r=%h c=%b v=%b z=%b n=%b cyc=%0d busy=1",
                   r, cout, ovf, zero, neg, cyc, busy, e.r, e.c, e.v, e.z, e.n, e.due);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] er, input logic ec, ev, ez, en, input int unsigned due);
    exp_t x;
    x = '{er, ec, ev, ez, en, due};
    exp_q.push_back(x);
  endtask

  // Called just after a rising edge; the next edge samples start.
  task automatic issue(input logic [7:0] ai, bi, input logic ci, ri,
                       input logic [7:0] er, input logic ec, ev, ez, en);
    a = ai; b = bi; cin = ci; resta = ri; start = 1'b1;
    push_exp(er, ec, ev, ez, en, cyc + 4);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n >= 60) begin
      bad++;
      $display("FAIL timeout got pending=%0d exp pending=0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  logic sweep_go  = 1'b0;
  int   sweep_fin = 0;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sw
      localparam int KK  = (gi == 0) ? 1 : ((gi == 1) ? 4 : 16);
      localparam int LAT = 16 / KK + 1;

      logic        st, sc, sr;
      logic [15:0] sa, sb, rr;
      logic        co, vo, zo, no, bo, dn;
      logic [19:0] q[$];
      int unsigned dq[$];
      logic [19:0] ex;
      int unsigned exd;

      sumador_secuencial_n_bits #(.N(16), .K(KK)) u (
        .clk(clk), .rst(rst), .start(st), .A(sa), .B(sb), .Cin(sc), .resta(sr),
        .R(rr), .Cout(co), .overflow(vo), .zero(zo), .negative(no),
        .busy(bo), .done(dn)
      );

      always @(negedge clk) begin
        if (dn) begin
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL sweep_k%0d_spurious got r=%h exp no done", KK, rr);
          end else begin
            ex  = q.pop_front();
            exd = dq.pop_front();
            if ({rr, co, vo, zo, no} !== ex || cyc != exd) begin
              bad++;
              $display("FAIL sweep_k%0d got r=%h c=%b v=%b z=%b n=%b cyc=%0d exp r=%h c=%b v=%b z=%b n=%b cyc=%0d",
                       KK, rr, co, vo, zo, no, cyc, ex[19:4], ex[3], ex[2], ex[1], ex[0], exd);
            end
          end
        end
      end

      initial begin
        logic [15:0] be;
        logic [16:0] full;
        logic        ov;
        int          n;
        st = 1'b0; sa = '0; sb = '0; sc = 1'b0; sr = 1'b0;
        wait (sweep_go);
        for (int i = 0; i < 300; i++) begin
          @(posedge clk); #1;
          sa = 16'($urandom);
          sb = 16'($urandom);
          sc = 1'($urandom);
          sr = 1'($urandom);
          be   = sr ? ~sb : sb;
          full = {1'b0, sa} + {1'b0, be} + {16'd0, (sr ? 1'b1 : sc)};
          ov   = (sa[15] == be[15]) && (full[15] != sa[15]);
          q.push_back({full[15:0], full[16], ov, (full[15:0] == 16'd0), full[15]});
          dq.push_back(cyc + 1 + LAT);
          st = 1'b1;
          @(posedge clk); #1;
          st = 1'b0;
          n = 0;
          while (q.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
          end
          if (n >= 40) begin
            total++;
            bad++;
            $display("FAIL sweep_k%0d_timeout got pending=%0d exp pending=0", KK, q.size());
            q.delete();
            dq.delete();
          end
        end
        sweep_fin++;
      end
    end
  endgenerate

  initial begin
    int n;
    int unsigned e0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; resta = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      start = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
      cin = 1'($urandom); resta = 1'($urandom);
    end
    @(posedge clk); #1;
    chk("reset_outputs", {24'd0, r}, 32'd0);
    chk("reset_flags", {27'd0, cout, ovf, zero, neg, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;

    issue(8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    wait_idle();
    chk("r_holds_in_idle", {24'd0, r}, 32'h41);
    issue(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_idle();
    issue(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_idle();
    issue(8'h05, 8'h05, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_idle();
    issue(8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // A start pulse mid-operation must be dropped.
    issue(8'h20, 8'h30, 1'b0, 1'b0, 8'h50, 1'b0, 1'b0, 1'b0, 1'b0);
    a = 8'h11; b = 8'h11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    wait_idle();

    // Held start: accepts at e0, e0+3, e0+6, e0+9.
    e0 = cyc + 1;
    a = 8'h01; b = 8'h02; cin = 1'b0; resta = 1'b0; start = 1'b1;
    push_exp(8'h03, 1'b0, 1'b0, 1'b0, 1'b0, e0 + 3);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      case (k)
        0: begin a = 8'h80; b = 8'h80; cin = 1'b0; resta = 1'b0;
                 push_exp(8'h00, 1'b1, 1'b1, 1'b1, 1'b0, e0 + 6); end
        1: begin a = 8'h10; b = 8'h20; cin = 1'b0; resta = 1'b1;
                 push_exp(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, e0 + 9); end
        2: begin a = 8'h40; b = 8'h3F; cin = 1'b1; resta = 1'b0;
                 push_exp(8'h80, 1'b0, 1'b1, 1'b0, 1'b1, e0 + 12); end
        default: start = 1'b0;
      endcase
      chk("b2b_busy", {31'd0, busy}, 32'd1);
      if (k < 3) begin
        repeat (2) begin
          @(posedge clk); #1;
          chk("b2b_busy", {31'd0, busy}, 32'd1);
        end
      end
    end
    wait_idle();

    // Reset during SUMA aborts the operation without a done pulse.
    a = 8'h12; b = 8'h34; cin = 1'b0; resta = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_r", {24'd0, r}, 32'd0);
    repeat (6) begin @(posedge clk); #1; end
    chk("abort_no_done_pending", exp_q.size(), 32'd0);

    issue(8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle();

    sweep_go = 1'b1;
    n = 0;
    while (sweep_fin < 3 && n < 40000) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (sweep_fin < 3) begin
      bad++;
      $display("FAIL sweep_timeout got finished=%0d exp finished=3", sweep_fin);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
